// File: rtl/iir_coef_loader_if.sv
// iir_coef_loader_if: configuration/control bus between the host and the IIR
// coefficient loader.
//   cfg_we/cfg_addr/cfg_data : shadow-bank write port (host -> loader)
//   apply                    : level-sampled load request (host -> loader)
//   run                      : user filter enable (host -> loader)
//   cfg_err                  : one-cycle pulse on a rejected write (loader -> host)
//   busy                     : load sequence in progress (loader -> host)
//   done                     : one-cycle pulse at end of a sequence (loader -> host)
interface iir_coef_loader_if;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 32;

   logic              cfg_we;
   logic [ADDR_W-1:0] cfg_addr;
   logic [DATA_W-1:0] cfg_data;
   logic              apply;
   logic              run;
   logic              cfg_err;
   logic              busy;
   logic              done;

   modport master (
      output cfg_we, cfg_addr, cfg_data, apply, run,
      input  cfg_err, busy, done
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_data, apply, run,
      output cfg_err, busy, done
   );
endinterface

// File: rtl/iir_coef_loader.sv
// iir_coef_loader: shadow bank of five Q16.16 IIR coefficients (n1,n2,n3,d1,d2)
// that is streamed into the filter's reg_select/coefficient port on request,
// with the filter gated off and its history cleared around the update.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   cfg (slave modport) : cfg_we/cfg_addr/cfg_data/apply/run in, cfg_err/busy/done out
//   reg_select          : coefficient index to the filter (registered)
//   enable_reg_select   : coefficient write strobe to the filter (registered)
//   coefficient         : coefficient value to the filter (registered)
//   n_1_reset           : filter history clear (registered)
//   filt_enable         : filter enable = run & ~busy (combinational from run)
// Build option: define IIR_COEF_AUTOLOAD_EN to run one load sequence
// automatically on the first edge after reset is released.
module iir_coef_loader #(
   parameter int unsigned NCOEF    = 5,
   parameter logic [31:0] N1_RESET = 32'h0001_0000
) (
   input  logic                clk,
   input  logic                reset,
   iir_coef_loader_if.slave    cfg,
   output logic [2:0]          reg_select,
   output logic                enable_reg_select,
   output logic [31:0]         coefficient,
   output logic                n_1_reset,
   output logic                filt_enable
);
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned COEF_W = 32;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                pending_q, pending_d;
   logic [COEF_W-1:0]   shadow_q [NCOEF];
   logic [COEF_W-1:0]   shadow_d [NCOEF];
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                cfg_err_q, cfg_err_d;
   logic [IDX_W-1:0]    sel_q, sel_d;
   logic                ers_q, ers_d;
   logic [COEF_W-1:0]   coef_q, coef_d;
   logic                n1rst_q, n1rst_d;
   logic                wr_ok;
   logic                auto_req;

`ifdef IIR_COEF_AUTOLOAD_EN
   // One-shot request armed by reset, consumed on the first non-reset edge.
   logic auto_q;
   always_ff @(posedge clk) begin
      if (reset) auto_q <= 1'b1;
      else       auto_q <= 1'b0;
   end
   assign auto_req = auto_q;
`else
   assign auto_req = 1'b0;
`endif

   // Next state, shadow update and next values of all registered outputs.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      pending_d = pending_q;
      shadow_d  = shadow_q;
      wr_ok     = cfg.cfg_we && (state_q == S_IDLE) && (cfg.cfg_addr <= LAST_IDX);
      cfg_err_d = cfg.cfg_we && !wr_ok;

      if (wr_ok) shadow_d[cfg.cfg_addr] = cfg.cfg_data;

      case (state_q)
         S_IDLE: begin
            if (cfg.apply || auto_req) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end
         end
         S_LOAD: begin
            pending_d = pending_q | cfg.apply;
            if (idx_q == LAST_IDX) state_d = S_FLUSH;
            else                   idx_d   = idx_q + IDX_W'(1);
         end
         S_FLUSH: begin
            pending_d = pending_q | cfg.apply;
            state_d   = S_DONE;
         end
         S_DONE: begin
            // A request seen during DONE is merged into the restart.
            pending_d = 1'b0;
            if (pending_q || cfg.apply) begin
               state_d = S_LOAD;
               idx_d   = '0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs follow the next state so they line up with it after the edge;
      // shadow_d lets a same-edge write reach word 0 of the sequence.
      busy_d  = (state_d != S_IDLE);
      ers_d   = (state_d == S_LOAD);
      sel_d   = ers_d ? idx_d : '0;
      coef_d  = ers_d ? shadow_d[idx_d] : '0;
      n1rst_d = (state_d == S_FLUSH);
      done_d  = (state_d == S_DONE);
   end

   // State, shadow bank and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         pending_q <= 1'b0;
         for (int unsigned i = 0; i < NCOEF; i++)
            shadow_q[i] <= (i == 0) ? N1_RESET : '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
         sel_q     <= '0;
         ers_q     <= 1'b0;
         coef_q    <= '0;
         n1rst_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         pending_q <= pending_d;
         shadow_q  <= shadow_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
         sel_q     <= sel_d;
         ers_q     <= ers_d;
         coef_q    <= coef_d;
         n1rst_q   <= n1rst_d;
      end
   end

   assign cfg.busy          = busy_q;
   assign cfg.done          = done_q;
   assign cfg.cfg_err       = cfg_err_q;
   assign reg_select        = sel_q;
   assign enable_reg_select = ers_q;
   assign coefficient       = coef_q;
   assign n_1_reset         = n1rst_q;
   assign filt_enable       = cfg.run & ~busy_q;
endmodule

// File: tb/tb_iir_coef_loader.sv
// tb_iir_coef_loader: bench for iir_coef_loader. Keeps its own model of the
// shadow bank; each load request queues the five expected (reg_select,
// coefficient) beats, which are popped as the loader streams them. A small
// IIR filter model consumes the loader outputs for the closed-loop case.
module tb_iir_coef_loader;
   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  reg_select;
   logic        enable_reg_select;
   logic [31:0] coefficient;
   logic        n_1_reset;
   logic        filt_enable;

   iir_coef_loader_if bus();

   iir_coef_loader dut (
      .clk               (clk),
      .reset             (reset),
      .cfg               (bus),
      .reg_select        (reg_select),
      .enable_reg_select (enable_reg_select),
      .coefficient       (coefficient),
      .n_1_reset         (n_1_reset),
      .filt_enable       (filt_enable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  sel;
      logic [31:0] coef;
   } beat_t;

   beat_t       exp_q[$];
   logic [31:0] sh [5];
   int          errors = 0;
   int          checks = 0;

   // Filter model: coefficients captured from the loader, Q16.16 direct form.
   logic signed [31:0] fc [5];
   logic signed [31:0] fx, fy, fx1, fx2, fy1, fy2;
   longint             acc;

   initial begin
      for (int i = 0; i < 5; i++) fc[i] = '0;
      fx = '0; fx1 = '0; fx2 = '0; fy1 = '0; fy2 = '0;
   end

   always_comb begin
      acc = longint'(fc[0]) * longint'(fx)  + longint'(fc[1]) * longint'(fx1)
          + longint'(fc[2]) * longint'(fx2) - longint'(fc[3]) * longint'(fy1)
          - longint'(fc[4]) * longint'(fy2);
      fy  = filt_enable ? 32'(acc >>> 16) : fx;
   end

   always @(posedge clk) begin
      if (enable_reg_select && reg_select < 3'd5) fc[reg_select] <= coefficient;
      if (n_1_reset) begin
         fx1 <= '0; fx2 <= '0; fy1 <= '0; fy2 <= '0;
      end else if (filt_enable) begin
         fx2 <= fx1; fx1 <= fx; fy2 <= fy1; fy1 <= fy;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sh_defaults();
      sh[0] = 32'h0001_0000;
      for (int i = 1; i < 5; i++) sh[i] = '0;
   endtask

   task automatic push_bank();
      for (int i = 0; i < 5; i++) exp_q.push_back('{sel: 3'(i), coef: sh[i]});
   endtask

   task automatic chk_flags(input string tag, input bit e_busy, input bit e_ers,
                            input bit e_n1, input bit e_done, input bit e_err);
      logic [4:0] got, exp;
      beat_t      b;
      got = {bus.busy, enable_reg_select, n_1_reset, bus.done, bus.cfg_err};
      exp = {e_busy, e_ers, e_n1, e_done, e_err};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s busy/ers/n1rst/done/err got %b expected %b", tag, got, exp);
      end
      checks++;
      if (filt_enable !== (bus.run & ~e_busy)) begin
         errors++;
         $display("FAIL %s filt_enable got %b expected %b", tag, filt_enable, bus.run & ~e_busy);
      end
      checks++;
      if (!e_ers) begin
         if ({reg_select, coefficient} !== 35'd0) begin
            errors++;
            $display("FAIL %s idle bus sel=%0d coef=%h expected 0", tag, reg_select, coefficient);
         end
      end else if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s beat with empty scoreboard sel=%0d coef=%h", tag, reg_select, coefficient);
      end else begin
         b = exp_q.pop_front();
         if (reg_select !== b.sel || coefficient !== b.coef) begin
            errors++;
            $display("FAIL %s beat sel=%0d coef=%h expected sel=%0d coef=%h",
                     tag, reg_select, coefficient, b.sel, b.coef);
         end
      end
   endtask

   // One load sequence (two when reapply_c>0). reapply_c / bad_c: cycle of the
   // sequence after which apply / a rejected write is driven.
   task automatic run_seq(input string tag, input bit use_apply,
                          input int reapply_c, input int bad_c);
      int nseq;
      nseq = (reapply_c > 0) ? 2 : 1;
      if (use_apply) bus.apply = 1'b1;
      push_bank();
      tick();
      for (int s = 0; s < nseq; s++) begin
         for (int c = 1; c <= 7; c++) begin
            if (c > 1 || s > 0) tick();
            chk_flags($sformatf("%s s%0d c%0d", tag, s, c), 1'b1, c <= 5, c == 6, c == 7,
                      bad_c > 0 && s == 0 && c == bad_c + 1);
            bus.apply    = (s == 0 && c == reapply_c);
            if (s == 0 && c == reapply_c) push_bank();
            bus.cfg_we   = (s == 0 && c == bad_c);
            bus.cfg_addr = 3'd2;
            bus.cfg_data = 32'hDEAD_BEEF;
         end
      end
      bus.cfg_we = 1'b0;
      tick();
      chk_flags({tag, " after"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s scoreboard left %0d expected 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic release_reset(input string tag);
      reset = 1'b0;
`ifdef IIR_COEF_AUTOLOAD_EN
      run_seq({tag, " autoload"}, 1'b0, 0, 0);
`else
      tick();
      chk_flags({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
   endtask

   task automatic wr(input int addr, input logic [31:0] data, input bit e_err);
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(addr);
      bus.cfg_data = data;
      tick();
      bus.cfg_we = 1'b0;
      checks++;
      if (bus.cfg_err !== e_err) begin
         errors++;
         $display("FAIL wr addr=%0d cfg_err got %b expected %b", addr, bus.cfg_err, e_err);
      end
      if (!e_err) sh[addr] = data;
   endtask

   task automatic test_reset();
      bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
      bus.apply = 1'b0; bus.run = 1'b1;
      reset = 1'b1;
      sh_defaults();
      tick();
      tick();
      chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.run = 1'b0;
      #1;
      checks++;
      if (filt_enable !== 1'b0) begin
         errors++;
         $display("FAIL reset run=0 filt_enable got %b expected 0", filt_enable);
      end
      bus.run = 1'b1;
      release_reset("reset release");
   endtask

   task automatic test_load();
      wr(0, 32'h0000_8000, 1'b0);
      wr(1, 32'h0000_4000, 1'b0);
      wr(3, 32'hFFFF_C000, 1'b0);
      run_seq("load", 1'b1, 0, 0);
   endtask

   task automatic test_cfg_err();
      wr(6, 32'h1111_1111, 1'b1);
      tick();
      chk_flags("err clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_seq("err busy", 1'b1, 0, 1);
      run_seq("reload", 1'b1, 0, 0);
   endtask

   task automatic test_back_to_back();
      run_seq("b2b", 1'b1, 2, 0);
   endtask

   task automatic test_reset_mid();
      bus.apply = 1'b1;
      tick();
      bus.apply = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      chk_flags("mid reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sh_defaults();
      exp_q.delete();
      release_reset("mid reset");
      run_seq("post reset", 1'b1, 0, 0);
   endtask

   task automatic test_same_edge();
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'd2;
      bus.cfg_data = 32'h0002_5000;
      sh[2]        = 32'h0002_5000;
      run_seq("same edge", 1'b1, 0, 0);
   endtask

   task automatic test_closed_loop();
      bus.run = 1'b1;
      fx      = 32'sd1000;
      reset   = 1'b1;
      tick();
      sh_defaults();
      exp_q.delete();
      release_reset("loop");
      run_seq("loop", 1'b1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (fy !== 32'sd1000) begin
            errors++;
            $display("FAIL loop y[%0d] got %0d expected 1000", i, fy);
         end
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_load();
      test_cfg_err();
      test_back_to_back();
      test_reset_mid();
      test_same_edge();
      test_closed_loop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/iir_coef_loader.md
# iir_coef_loader

Coefficient sequencer placed directly upstream of the IIR integrator filter. Holds a shadow bank of five Q16.16 coefficients (n1, n2, n3, d1, d2) written from the configuration bus. On an `apply` request it gates the filter off, streams the bank into the filter's `reg_select`/`coefficient` port one word per cycle, and pulses the filter history clear. It then re-enables filtering, so the filter never runs on a partially updated coefficient set.

## Interface
Parameters:
- `NCOEF`, 5, number of coefficient words; fixed by the filter's `reg_select` map 0..4.
- `N1_RESET`, 32'h0001_0000, shadow n1 reset value (1.0 in Q16.16); gives pass-through.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `cfg_we`  in  1  shadow write strobe.
- `cfg_addr`  in  3  shadow index: 0=n1, 1=n2, 2=n3, 3=d1, 4=d2.
- `cfg_data`  in  32  signed Q16.16 coefficient.
- `apply`  in  1  level-sampled request to load the shadow bank into the filter.
- `run`  in  1  user filter enable.
- `busy`  out  1  high while a load sequence is in progress.
- `done`  out  1  one-cycle pulse when a sequence completes.
- `cfg_err`  out  1  one-cycle pulse on a rejected write.
- `reg_select`  out  3  to filter.
- `enable_reg_select`  out  1  to filter.
- `coefficient`  out  32  to filter.
- `n_1_reset`  out  1  to filter; clears filter history.
- `filt_enable`  out  1  to filter `enable`; equals `run & ~busy`.

## Operation
- Shadow bank reset values: n1=`N1_RESET`, n2=n3=d1=d2=0.
- Shadow write: `cfg_we`=1 in IDLE with `cfg_addr`≤4 writes the shadow word at the next edge.
- Rejected writes: `cfg_addr` 5..7, or any `cfg_we` while `busy`. The shadow is unchanged and `cfg_err` pulses one cycle later.
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE → LOAD when `apply`=1. The index counter is set to 0.
  - LOAD: drives `enable_reg_select`=1, `reg_select`=idx, `coefficient`=shadow[idx]. idx increments each cycle. After idx=4 the FSM goes to FLUSH.
  - FLUSH: one cycle with `n_1_reset`=1 and `enable_reg_select`=0. Next state is DONE.
  - DONE: one cycle with `done`=1, then IDLE.
- `busy`=1 in LOAD, FLUSH and DONE.
- Pending request: `apply`=1 while `busy` sets a pending flag. In DONE, if pending is set, the FSM goes to LOAD instead of IDLE and clears pending. At most one request is queued; further requests while pending is set are merged into it.
- `apply` held high in IDLE starts back-to-back sequences.
- Outputs to the filter are registered. When not in LOAD: `reg_select`=0, `coefficient`=0, `enable_reg_select`=0.

## Timing
- Reset values:
  - All outputs 0.
  - `filt_enable` = `run` (since `busy`=0).
  - FSM in IDLE; pending flag and index counter cleared.
- `apply` sampled high in IDLE at edge k gives:
  - `busy`=1 from cycle k+1 to k+7.
  - `enable_reg_select`=1 in cycles k+1..k+5, with `reg_select` 0,1,2,3,4.
  - `n_1_reset`=1 in cycle k+6.
  - `done`=1 in cycle k+7.
  - `busy`=0 and `filt_enable`=`run` from k+8.
- Total sequence: 7 cycles, with `filt_enable`=0 throughout.
- `filt_enable` is combinational from `run` and registered `busy`, with zero-cycle response to `run`.
- `reset` mid-sequence: returns to IDLE at the next edge, all outputs go to 0, pending is dropped, and the shadow bank returns to its reset values.
- `cfg_we` and `apply` on the same edge in IDLE: the write is accepted and the sequence starts. Word 0 is loaded in cycle k+1 from the already-updated shadow.

## Configuration
- `IIR_COEF_AUTOLOAD_EN`:
  - Defined: after `reset` deasserts, one load sequence runs automatically, as if `apply`=1 were sampled on the first non-reset edge. The filter therefore starts with the pass-through bank.
  - Undefined: the filter stays unloaded until the first `apply`.

## Test plan
- Write n1=0x0000_8000, n2=0x0000_4000, d1=0xFFFF_C000, then pulse `apply` → cycles k+1..k+5 show `reg_select` 0..4 with `coefficient` 8000, 4000, 0, FFFFC000, 0. Then `n_1_reset` at k+6, `done` at k+7, `filt_enable` low for k+1..k+7.
- `cfg_we` with `cfg_addr`=6, and `cfg_we` during LOAD → `cfg_err` pulses one cycle later each time; a full reload then shows the shadow unchanged.
- `apply` pulsed at k+2 during a sequence → a second sequence starts at k+8 (LOAD directly after DONE, no IDLE cycle); `done` pulses at k+7 and k+14.
- `reset` asserted at k+3 → next cycle all outputs are 0. A following `apply` loads n1=0x0001_0000 and all other words 0.
- Closed loop with the filter model and the default bank, `run`=1: x=1000 → y=1000 after the sequence; y stays at the raw input during the load.
- With `IIR_COEF_AUTOLOAD_EN` defined: release `reset` at edge r → `enable_reg_select` is high in cycles r+1..r+5 and `done` pulses at r+7 with no `apply`.
